// File: rtl/spi_slv.sv
// spi_slv: 16-bit SPI responder (peripheral end of the link).
// Receives a command word on MOSI and returns a response word on MISO
// within the same SS_n frame. SCLK idles high; data is MSB first.
//
// Ports:
//   clk        system clock (>= 8x SCLK)
//   rst        synchronous active-high reset
//   SCLK       serial clock from master (async)
//   SS_n       active-low frame select (async)
//   MOSI       serial data from master (async)
//   MISO       serial data to master
//   tx_data    response word, captured at frame start
//   rx_data    last complete received word
//   rdy        sticky: new rx_data valid (cleared by clr_rdy, set wins)
//   clr_rdy    clears rdy
//   frame_err  sticky: last frame had the wrong bit count
//   busy       frame in progress
//
// state  | meaning
// IDLE   | waiting for an SS_n fall
// ACTIVE | frame in progress: count SCLK rises, shift rx/tx
module spi_slv #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rdy,
  input  logic              clr_rdy,
  output logic              frame_err,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [1:0]       FLUSH_INIT = 2'd3;

  // Sync chains: bit0 = ff1, bit1 = ff2, bit2 = ff3
  logic [2:0] sclk_sync_q, ss_sync_q, mosi_sync_q;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   tx_shft_q, tx_shft_d;
  logic [DATA_W-1:0]   rx_shft_q, rx_shft_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rdy_q, rdy_d;
  logic                frame_err_q, frame_err_d;
  // After reset the SS_n chain starts at 1, so an SS_n already held low
  // would look like a fall. The flush timer lets the chain settle, and a
  // frame is only accepted once SS_n has been seen high afterwards.
  logic [1:0]          flush_q, flush_d;
  logic                armed_q, armed_d;

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= 3'b111;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 3'b000;
      state_q     <= IDLE;
      tx_shft_q   <= '0;
      rx_shft_q   <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      flush_q     <= FLUSH_INIT;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
      ss_sync_q   <= {ss_sync_q[1:0], SS_n};
      mosi_sync_q <= {mosi_sync_q[1:0], MOSI};
      state_q     <= state_d;
      tx_shft_q   <= tx_shft_d;
      rx_shft_q   <= rx_shft_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_shft_d   = tx_shft_q;
    rx_shft_d   = rx_shft_q;
    bit_cnt_d   = bit_cnt_q;
    rx_data_d   = rx_data_q;
    rdy_d       = rdy_q;
    frame_err_d = frame_err_q;
    flush_d     = (flush_q != 2'd0) ? flush_q - 2'd1 : flush_q;
    armed_d     = armed_q | ((flush_q == 2'd0) & ss_sync_q[2]);

    if (clr_rdy) rdy_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ss_fall && armed_q) begin
          tx_shft_d   = tx_data;
          bit_cnt_d   = '0;
          rx_shft_d   = '0;
          frame_err_d = 1'b0;
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          rx_shft_d = {rx_shft_q[DATA_W-2:0], mosi_sync_q[1]};
          if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else if (sclk_fall && (bit_cnt_q != '0)) begin
          tx_shft_d = {tx_shft_q[DATA_W-2:0], 1'b0};
        end
        // Uses the updated count/shift so a coincident final rise is included.
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_d == FULL_CNT) begin
            rx_data_d = rx_shft_d;
            rdy_d     = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO      = tx_shft_q[DATA_W-1];
  assign rx_data   = rx_data_q;
  assign rdy       = rdy_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slv.sv
// tb_spi_slv: directed self-checking bench for spi_slv with a bit-banged
// SPI master running at 32 clk per SCLK period.
module tb_spi_slv;

  logic        clk = 1'b0;
  logic        rst, SCLK, SS_n, MOSI, clr_rdy;
  logic        MISO, rdy, frame_err, busy;
  logic [15:0] tx_data, rx_data, rd;
  logic        busy_mid;
  int          errors = 0;
  int          checks = 0;
  bit          seen;

  always #5 clk = ~clk;

  spi_slv #(.DATA_W(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .tx_data(tx_data), .rx_data(rx_data), .rdy(rdy),
    .clr_rdy(clr_rdy), .frame_err(frame_err), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: leading fall, nrise rising edges, SS_n released with SCLK high.
  // MOSI changes 2 clks after each rise; MISO is sampled 4 clks after each rise.
  // rst_at > 0 pulses rst right after that many rises.
  task automatic send_frame(input logic [15:0] d, input int nrise, input int rst_at,
                            output logic [15:0] rdo);
    logic [15:0] dd;
    rdo = '0;
    wait_clks(4);
    SS_n = 1'b0;
    wait_clks(8);
    MOSI = d[15];
    tx_data = ~tx_data;  // captured copy must be unaffected
    SCLK = 1'b0;
    for (int i = 0; i < nrise; i++) begin
      wait_clks(16);
      SCLK = 1'b1;
      wait_clks(2);
      dd = d << (i + 1);
      MOSI = dd[15];
      wait_clks(2);
      if (i < 16) rdo[15-i] = MISO;
      if (i == 4) busy_mid = busy;
      if (i + 1 == rst_at) begin
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        check("rst_miso", MISO, 0);
        check("rst_rx", rx_data, 0);
        check("rst_rdy", rdy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        wait_clks(11);
      end else begin
        wait_clks(12);
      end
      if (i < nrise - 1) SCLK = 1'b0;
    end
    wait_clks(8);
    SS_n = 1'b1;
  endtask

  initial begin
    rst = 1'b1; SCLK = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
    clr_rdy = 1'b0; tx_data = '0; busy_mid = 1'b0;
    wait_clks(3);
    check("reset_miso", MISO, 0);
    check("reset_rx", rx_data, 0);
    check("reset_rdy", rdy, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    wait_clks(8);

    // 1: basic exchange
    tx_data = 16'h3C5A;
    send_frame(16'hA5C3, 16, 0, rd);
    wait_clks(4);
    check("t1_busy_mid", busy_mid, 1);
    check("t1_rx", rx_data, 16'hA5C3);
    check("t1_rdy", rdy, 1);
    check("t1_rd", rd, 16'h3C5A);
    check("t1_ferr", frame_err, 0);
    check("t1_busy_end", busy, 0);

    // 2: back-to-back frames, rdy stays set; then clear
    tx_data = 16'h8001;
    send_frame(16'h0001, 16, 0, rd);
    wait_clks(4);
    check("t2_rx_a", rx_data, 16'h0001);
    check("t2_rd_a", rd, 16'h8001);
    check("t2_rdy_a", rdy, 1);
    send_frame(16'hFFFF, 16, 0, rd);
    wait_clks(4);
    check("t2_rx_b", rx_data, 16'hFFFF);
    check("t2_rdy_b", rdy, 1);
    clr_rdy = 1'b1;
    wait_clks(1);
    clr_rdy = 1'b0;
    check("t2_clr", rdy, 0);

    // 3: short frame, then a good frame clears frame_err
    send_frame(16'hAB00, 8, 0, rd);
    wait_clks(4);
    check("t3_ferr", frame_err, 1);
    check("t3_rdy", rdy, 0);
    check("t3_rx_hold", rx_data, 16'hFFFF);
    tx_data = 16'h0F0F;
    send_frame(16'h5A5A, 16, 0, rd);
    wait_clks(4);
    check("t3_ferr_clr", frame_err, 0);
    check("t3_rx", rx_data, 16'h5A5A);
    check("t3_rd", rd, 16'h0F0F);
    check("t3_rdy_set", rdy, 1);

    // 4: long frames; 48 rises would alias to 16 without saturation
    clr_rdy = 1'b1;
    wait_clks(1);
    clr_rdy = 1'b0;
    send_frame(16'h1111, 20, 0, rd);
    wait_clks(4);
    check("t4_ferr20", frame_err, 1);
    check("t4_rdy20", rdy, 0);
    check("t4_rx20", rx_data, 16'h5A5A);
    send_frame(16'h2222, 48, 0, rd);
    wait_clks(4);
    check("t4_ferr48", frame_err, 1);
    check("t4_rdy48", rdy, 0);
    check("t4_rx48", rx_data, 16'h5A5A);

    // 5: reset after 9 bits; rest of frame ignored; then a clean frame
    send_frame(16'hFFFF, 16, 9, rd);
    wait_clks(4);
    check("t5_rx_after", rx_data, 0);
    check("t5_rdy_after", rdy, 0);
    check("t5_ferr_after", frame_err, 0);
    check("t5_busy_after", busy, 0);
    tx_data = 16'hBEEF;
    send_frame(16'h1234, 16, 0, rd);
    wait_clks(4);
    check("t5_rx", rx_data, 16'h1234);
    check("t5_rd", rd, 16'hBEEF);
    check("t5_rdy", rdy, 1);

    // 6: clr_rdy held through completion: set wins, then cleared
    clr_rdy = 1'b1;
    send_frame(16'hC0DE, 16, 0, rd);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (rx_data === 16'hC0DE) seen = 1'b1;
    end
    check("t6_complete", seen, 1);
    check("t6_rdy_set", rdy, 1);
    wait_clks(1);
    check("t6_rdy_clr", rdy, 0);
    clr_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
